// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline: bubble word, default reset PC and
// the fetch control state encoding.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } fetch_state_t;

    // Instruction addresses are word aligned; stray low bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID pipeline register bundle: fetch drives it, decode consumes it.
interface fetch_stage_if;

    logic [31:0] instruction_ID;
    logic [31:0] pc_plus4_ID;
    logic        valid_ID;

    modport master (
        output instruction_ID,
        output pc_plus4_ID,
        output valid_ID
    );

    modport slave (
        input instruction_ID,
        input pc_plus4_ID,
        input valid_ID
    );

endinterface

// File: rtl/pc_register.sv
// Program counter with synchronous reset, redirect load, stall hold and a
// free-running +4 incrementer.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    // Load beats hold so a redirect escapes a stalled wrong-path fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (!hold) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register with bubble insertion on
// redirect, stall handling and fetch/stall performance counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    fetch_stage_if.master        id_bus,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .hold     (stall),
        .load     (redirect),
        .load_pc  (align_word(redirect_pc)),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign imem_addr = pc;

    // BUBBLE only marks the first cycle out of reset; fetch behaves the same in both states.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= BUBBLE;
            id_bus.instruction_ID <= NOP_WORD;
            id_bus.pc_plus4_ID    <= 32'd0;
            id_bus.valid_ID       <= 1'b0;
            fetch_count           <= 32'd0;
            stall_count           <= 32'd0;
        end else begin
            case (state)
                BUBBLE:  state <= RUN;
                default: state <= RUN;
            endcase

            if (redirect) begin
                id_bus.instruction_ID <= NOP_WORD;
                id_bus.valid_ID       <= 1'b0;
            end else if (stall) begin
                stall_count <= stall_count + 32'd1;
            end else begin
                id_bus.instruction_ID <= imem_rdata;
                id_bus.pc_plus4_ID    <= pc_plus4;
                id_bus.valid_ID       <= 1'b1;
                fetch_count           <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// reset/stall/redirect traffic, compared against a behavioural model.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] fetchCount;
    logic [31:0] stallCount;

    logic [31:0] mem [0:255];

    logic [31:0] pcModel;
    logic [31:0] instrModel;
    logic [31:0] pc4Model;
    logic        validModel;
    logic [31:0] fetchModel;
    logic [31:0] stallModel;

    int testCount = 0;
    int failCount = 0;

    fetch_stage_if idBus ();

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .imem_addr   (imemAddr),
        .imem_rdata  (imemRdata),
        .id_bus      (idBus),
        .fetch_count (fetchCount),
        .stall_count (stallCount)
    );

    assign imemRdata = mem[imemAddr[9:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, advance the model by the edge rules, then compare everything.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] rpc);
        @(negedge clock);
        reset      = r;
        stall      = s;
        redirect   = rd;
        redirectPc = rpc;
        @(posedge clock);
        if (r) begin
            pcModel    = 32'h0;
            instrModel = 32'h0;
            pc4Model   = 32'h0;
            validModel = 1'b0;
            fetchModel = 32'h0;
            stallModel = 32'h0;
        end else if (rd) begin
            pcModel    = (rpc / 4) * 4;
            instrModel = 32'h0;
            validModel = 1'b0;
        end else if (s) begin
            stallModel = stallModel + 1;
        end else begin
            instrModel = mem[pcModel[9:2]];
            pc4Model   = pcModel + 4;
            validModel = 1'b1;
            pcModel    = pcModel + 4;
            fetchModel = fetchModel + 1;
        end
        #1;
        checkOutput("imem_addr", imemAddr, pcModel);
        checkOutput("instruction_ID", idBus.instruction_ID, instrModel);
        checkOutput("pc_plus4_ID", idBus.pc_plus4_ID, pc4Model);
        checkOutput("valid_ID", {31'd0, idBus.valid_ID}, {31'd0, validModel});
        checkOutput("fetch_count", fetchCount, fetchModel);
        checkOutput("stall_count", stallCount, stallModel);
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;

        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("reset valid", {31'd0, idBus.valid_ID}, 32'd0);
        checkOutput("reset addr", imemAddr, 32'h0);

        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("first instr", idBus.instruction_ID, 32'h2008_0005);
        checkOutput("first pc4", idBus.pc_plus4_ID, 32'd4);
        applyStimulus(0, 0, 0, 32'h0);

        applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("stall hold instr", idBus.instruction_ID, 32'h2009_0003);
        checkOutput("stall hold addr", imemAddr, 32'd8);
        checkOutput("stall count 2", stallCount, 32'd2);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("resume instr", idBus.instruction_ID, 32'h0109_5020);
        checkOutput("fetch count 3", fetchCount, 32'd3);

        applyStimulus(0, 0, 1, 32'h40);
        checkOutput("redirect bubble", idBus.instruction_ID, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("redirect target", idBus.instruction_ID, mem[16]);
        checkOutput("redirect pc4", idBus.pc_plus4_ID, 32'h44);

        applyStimulus(0, 1, 1, 32'h23);
        checkOutput("stall+redirect pc", imemAddr, 32'h20);
        checkOutput("stall+redirect count", stallCount, 32'd2);
        applyStimulus(0, 0, 0, 32'h0);

        applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("wrap pc4", idBus.pc_plus4_ID, 32'h0);
        checkOutput("wrap addr", imemAddr, 32'h0);

        applyStimulus(0, 0, 1, 32'h10);
        applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("mid reset addr", imemAddr, 32'h0);
        checkOutput("mid reset stalls", stallCount, 32'h0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
